unbinning_2x2: RTL and testbench

- 2x2 pixel-replication upscaler: converts an X/2 * Y/2 stream into X * Y. Every input pixel is emitted twice horizontally; every input line is emitted twice vertically.
- Sits downstream of the 2x2 binning stage, or any other half-rate source, to restore full resolution.
- Each completed input line is stored in a ping-pong line buffer. An output FSM replays it as two self-timed output lines.

---
 rtl/unbinning_2x2.sv | 169 ++++++++++++++++
 tb/tb_unbinning_2x2.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/unbinning_2x2.sv
// 2x2 pixel-replication upscaler: each input line lands in a ping-pong line
// buffer and is replayed as two doubled-width output lines. Optional macro
// UNBINNING_2X2_INTERP_EN swaps horizontal replication for linear interpolation.
module unbinning_2x2 #(
  parameter int LINE_SIZE_MAX = 1024,
  parameter int PIXEL_WIDTH   = 8,
  parameter int HBLANK_OUT    = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   bypass,
  input  logic [PIXEL_WIDTH-1:0] di_i,
  input  logic                   de_i,
  input  logic                   hs_i,
  input  logic                   vs_i,
  output logic [PIXEL_WIDTH-1:0] do_o,
  output logic                   de_o,
  output logic                   hs_o,
  output logic                   vs_o,
  output logic                   ovf_o
);
  localparam int AW = $clog2(LINE_SIZE_MAX + 1);
  localparam int IW = $clog2(LINE_SIZE_MAX);
  localparam int CW = $clog2(2 * LINE_SIZE_MAX + HBLANK_OUT);
`ifdef UNBINNING_2X2_INTERP_EN
  localparam int STAGES = 2;
`else
  localparam int STAGES = 1;
`endif

  typedef enum logic [2:0] {IDLE, LINE_A, HBLK_A, LINE_B, HBLK_B} state_t;

  state_t                   state_q;
  logic [CW-1:0]            cnt_q;
  logic [AW-1:0]            wptr_q, len_q, wlen_d;
  logic                     wr_sel_q, rd_sel_q, start_q, hs_prev_q, byp_q, ovf_q;
  logic [STAGES-1:0]        vld_pipe;
  logic [PIXEL_WIDTH-1:0]   mem_q [2][LINE_SIZE_MAX];
  logic [PIXEL_WIDTH-1:0]   rd_q, pix_d, do_q;
  logic                     de_q, hs_q, vs_q;
  logic [IW-1:0]            raddr;
  logic                     wr_en, line_end, idle_w, idle_all, accept, drop;
  logic                     line_act, line_last, blank_last, busy;

  assign wr_en    = !byp_q && vs_i && de_i && (wptr_q != AW'(LINE_SIZE_MAX));
  assign wlen_d   = wptr_q + AW'(wr_en);
  assign line_end = !byp_q && hs_i && !hs_prev_q;
  assign idle_w   = (state_q == IDLE) && !start_q;
  assign idle_all = idle_w && (vld_pipe == '0);
  assign accept   = line_end && (wlen_d != '0) && idle_w;
  assign drop     = line_end && (wlen_d != '0) && !idle_w;

  assign line_act   = (state_q == LINE_A) || (state_q == LINE_B);
  assign line_last  = cnt_q == (CW'({len_q, 1'b0}) - CW'(1));
  assign blank_last = cnt_q == CW'(HBLANK_OUT - 1);
  assign busy       = (state_q != IDLE) || start_q || (vld_pipe != '0);

  // Write side, line-end decision and deferred bypass switch.
  always_ff @(posedge clk) begin
    if (rst) begin
      hs_prev_q <= 1'b1;
      wptr_q    <= '0;
      len_q     <= '0;
      wr_sel_q  <= 1'b0;
      rd_sel_q  <= 1'b0;
      start_q   <= 1'b0;
      ovf_q     <= 1'b0;
      byp_q     <= 1'b0;
    end else begin
      hs_prev_q <= hs_i;
      start_q   <= accept;
      ovf_q     <= drop;
      if (accept) begin
        len_q    <= wlen_d;
        rd_sel_q <= wr_sel_q;
        wr_sel_q <= ~wr_sel_q;
      end
      if (byp_q || line_end || !vs_i) wptr_q <= '0;
      else if (wr_en)                 wptr_q <= wptr_q + AW'(1);
      if (idle_all && !accept) byp_q <= bypass;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_sel_q][wptr_q[IW-1:0]] <= di_i;
    rd_q <= mem_q[rd_sel_q][raddr];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE:   if (start_q) begin state_q <= LINE_A; cnt_q <= '0; end
        LINE_A: if (line_last) begin state_q <= HBLK_A; cnt_q <= '0; end
                else cnt_q <= cnt_q + CW'(1);
        HBLK_A: if (blank_last) begin state_q <= LINE_B; cnt_q <= '0; end
                else cnt_q <= cnt_q + CW'(1);
        LINE_B: if (line_last) begin state_q <= HBLK_B; cnt_q <= '0; end
                else cnt_q <= cnt_q + CW'(1);
        HBLK_B: if (blank_last) begin state_q <= IDLE; cnt_q <= '0; end
                else cnt_q <= cnt_q + CW'(1);
        default: begin state_q <= IDLE; cnt_q <= '0; end
      endcase
    end
  end

`ifdef UNBINNING_2X2_INTERP_EN
  // Read one pixel ahead (ceil(slot/2), clamped) so odd slots see p[k] and p[k+1].
  logic [CW-1:0]          half_up, last;
  logic [PIXEL_WIDTH-1:0] cur_q, prv_q;
  logic [PIXEL_WIDTH:0]   sum;
  logic [STAGES-1:0]      odd_pipe;

  assign half_up = (cnt_q + CW'(1)) >> 1;
  assign last    = CW'(len_q) - CW'(1);
  assign raddr   = (half_up > last) ? last[IW-1:0] : half_up[IW-1:0];
  assign sum     = {1'b0, prv_q} + {1'b0, cur_q} + (PIXEL_WIDTH+1)'(1);
  assign pix_d   = odd_pipe[STAGES-1] ? sum[PIXEL_WIDTH:1] : cur_q;

  always_ff @(posedge clk) begin
    cur_q <= rd_q;
    prv_q <= cur_q;
  end

  always_ff @(posedge clk) begin
    if (rst) odd_pipe <= '0;
    else begin
      odd_pipe[0] <= cnt_q[0];
      for (int i = 1; i < STAGES; i++) odd_pipe[i] <= odd_pipe[i-1];
    end
  end
`else
  assign raddr = cnt_q[IW:1];
  assign pix_d = rd_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
      do_q     <= '0;
      de_q     <= 1'b0;
      hs_q     <= 1'b1;
      vs_q     <= 1'b0;
    end else begin
      vld_pipe[0] <= line_act;
      for (int i = 1; i < STAGES; i++) vld_pipe[i] <= vld_pipe[i-1];
      if (byp_q) begin
        do_q <= di_i;
        de_q <= de_i;
        hs_q <= hs_i;
        vs_q <= vs_i;
      end else begin
        if (vld_pipe[STAGES-1]) do_q <= pix_d;
        de_q <= vld_pipe[STAGES-1];
        hs_q <= ~vld_pipe[STAGES-1];
        // Stretch the frame so the tail of the last replay stays inside vs_o.
        vs_q <= vs_i || busy;
      end
    end
  end

  assign do_o  = do_q;
  assign de_o  = de_q;
  assign hs_o  = hs_q;
  assign vs_o  = vs_q;
  assign ovf_o = ovf_q;
endmodule

// File: tb/tb_unbinning_2x2.sv
// Randomized bench for unbinning_2x2: outputs are logged per cycle and compared
// against whole-line expectations built from pixel lists.
module tb_unbinning_2x2;
  localparam int LSM  = 8;
  localparam int PW   = 8;
  localparam int HB   = 16;
  localparam int LOGN = 16384;
`ifdef UNBINNING_2X2_INTERP_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 3;
`endif

  typedef logic [PW-1:0] pix_q_t[$];

  logic          clk = 1'b0, rst = 1'b1, bypass = 1'b0;
  logic [PW-1:0] di_i = '0;
  logic          de_i = 1'b0, hs_i = 1'b1, vs_i = 1'b0;
  logic [PW-1:0] do_o;
  logic          de_o, hs_o, vs_o, ovf_o;

  unbinning_2x2 #(.LINE_SIZE_MAX(LSM), .PIXEL_WIDTH(PW), .HBLANK_OUT(HB)) dut (
    .clk(clk), .rst(rst), .bypass(bypass),
    .di_i(di_i), .de_i(de_i), .hs_i(hs_i), .vs_i(vs_i),
    .do_o(do_o), .de_o(de_o), .hs_o(hs_o), .vs_o(vs_o), .ovf_o(ovf_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [PW-1:0] lg_do [LOGN];
  logic          lg_de [LOGN], lg_hs [LOGN], lg_vs [LOGN], lg_ovf [LOGN];
  always @(negedge clk) if (cyc < LOGN) begin
    lg_do[cyc] = do_o; lg_de[cyc] = de_o; lg_hs[cyc] = hs_o;
    lg_vs[cyc] = vs_o; lg_ovf[cyc] = ovf_o;
  end

  int total = 0, bad = 0;

  task automatic step(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // One output line: each stored pixel fills two slots (replicated or interpolated).
  function automatic pix_q_t expect_line(input pix_q_t p);
    pix_q_t e;
    int n = (p.size() > LSM) ? LSM : p.size();
    for (int k = 0; k < n; k++) begin
      e.push_back(p[k]);
`ifdef UNBINNING_2X2_INTERP_EN
      if (k < n - 1) e.push_back(PW'((int'(p[k]) + int'(p[k+1]) + 1) / 2));
      else           e.push_back(p[k]);
`else
      e.push_back(p[k]);
`endif
    end
    return e;
  endfunction

  function automatic string exp_frame(input pix_q_t p);
    pix_q_t e = expect_line(p);
    string s = "__ ";
    foreach (e[i]) s = {s, $sformatf("%02h ", e[i])};
    repeat (HB) s = {s, "__ "};
    foreach (e[i]) s = {s, $sformatf("%02h ", e[i])};
    s = {s, "__ "};
    return s;
  endfunction

  function automatic string obs_frame(input int r, input int n);
    string s = "";
    for (int i = r + LAT - 1; i <= r + LAT + 2 * n + HB; i++) begin
      if (i < 0 || i >= LOGN)                     s = {s, "?? "};
      else if (lg_de[i] === 1'b1 && lg_hs[i] === 1'b0) s = {s, $sformatf("%02h ", lg_do[i])};
      else if (lg_de[i] === 1'b0 && lg_hs[i] === 1'b1) s = {s, "__ "};
      else                                         s = {s, "!! "};
    end
    return s;
  endfunction

  function automatic pix_q_t rand_line(input int n);
    pix_q_t p;
    repeat (n) p.push_back(PW'($urandom));
    return p;
  endfunction

  // gap < 0 picks a random 0..2 idle clocks between pixels.
  task automatic drive_line(input pix_q_t p, input int gap, output int rise);
    hs_i = 1'b0; vs_i = 1'b1;
    foreach (p[k]) begin
      di_i = p[k]; de_i = 1'b1;
      step();
      de_i = 1'b0;
      step((gap < 0) ? int'($urandom_range(2, 0)) : gap);
    end
    hs_i = 1'b1;
    rise = cyc + 1;
  endtask

  task automatic test_reset();
    rst = 1'b1; step(3); rst = 1'b0;
    for (int i = 0; i < 100; i++) begin
      step();
      total++;
      if ({do_o, de_o, hs_o, vs_o, ovf_o} !== {8'h00, 1'b0, 1'b1, 1'b0, 1'b0}) begin
        bad++;
        $display("FAIL reset_idle cyc=%0d: got do=%0h de=%b hs=%b vs=%b ovf=%b want 0 0 1 0 0",
                 cyc, do_o, de_o, hs_o, vs_o, ovf_o);
      end
    end
  endtask

  task automatic test_basic();
    pix_q_t p, e;
    int r, n, vbad, ov;
    string o, x;
    p = '{8'd10, 8'd20, 8'd30, 8'd40};
    e = expect_line(p); n = e.size();
    drive_line(p, 1, r);
    step(); vs_i = 1'b0;
    step(LAT + 2 * (n + HB) + 4);
    o = obs_frame(r, n); x = exp_frame(p);
    total++;
    if (o != x) begin bad++; $display("FAIL basic_frame: got %s want %s", o, x); end
    total++;
    if (lg_do[r + LAT + n] !== e[n-1]) begin
      bad++; $display("FAIL basic_hold: got %0h want %0h", lg_do[r + LAT + n], e[n-1]);
    end
    vbad = 0; ov = 0;
    for (int i = r; i < cyc; i++) begin
      if (lg_de[i] === 1'b1 && lg_vs[i] !== 1'b1) vbad++;
      if (lg_ovf[i] !== 1'b0) ov++;
    end
    total++;
    if (vbad != 0 || ov != 0) begin
      bad++; $display("FAIL basic_vs_ovf: got vs_low_during_de=%0d ovf=%0d want 0 0", vbad, ov);
    end
    total++;
    if (vs_o !== 1'b0) begin bad++; $display("FAIL basic_vs_end: got %b want 0", vs_o); end
    p = '{8'd0, 8'd255, 8'd100};
    n = expect_line(p).size();
    drive_line(p, 0, r);
    step(LAT + 2 * (n + HB) + 6);
    o = obs_frame(r, n); x = exp_frame(p);
    total++;
    if (o != x) begin bad++; $display("FAIL edge_values_frame: got %s want %s", o, x); end
  endtask

  task automatic test_random();
    int lens[6] = '{1, 8, 3, 5, 2, 7};
    pix_q_t p;
    int r, n;
    string o, x;
    foreach (lens[j]) begin
      p = rand_line(lens[j]);
      n = expect_line(p).size();
      drive_line(p, -1, r);
      step(LAT + 2 * (n + HB) + 6);
      o = obs_frame(r, n); x = exp_frame(p);
      total++;
      if (o != x) begin bad++; $display("FAIL random_len%0d: got %s want %s", lens[j], o, x); end
    end
  endtask

  task automatic test_vs_clear();
    pix_q_t p;
    int r, n;
    string o, x;
    hs_i = 1'b0; vs_i = 1'b1;
    for (int i = 0; i < 3; i++) begin di_i = PW'(8'hE0 + i); de_i = 1'b1; step(); end
    de_i = 1'b0; vs_i = 1'b0; step();
    p = rand_line(4);
    n = expect_line(p).size();
    drive_line(p, 0, r);
    step(LAT + 2 * (n + HB) + 6);
    o = obs_frame(r, n); x = exp_frame(p);
    total++;
    if (o != x) begin bad++; $display("FAIL vs_clear_frame: got %s want %s", o, x); end
  endtask

  task automatic test_overflow();
    pix_q_t p1, p2, p3;
    int r1, r2, r3, n, ov, extra;
    string o, x;
    p1 = '{8'd1, 8'd2, 8'd3, 8'd4};
    p2 = '{8'd5, 8'd6, 8'd7, 8'd8};
    p3 = '{8'd9, 8'd10, 8'd11, 8'd12};
    n = expect_line(p1).size();
    drive_line(p1, 1, r1);
    step(12);
    drive_line(p2, 1, r2);
    step(LAT + 2 * (n + HB) + 4);
    o = obs_frame(r1, n); x = exp_frame(p1);
    total++;
    if (o != x) begin bad++; $display("FAIL ovf_first_frame: got %s want %s", o, x); end
    ov = 0;
    for (int i = r1; i < cyc; i++) if (lg_ovf[i] === 1'b1) ov++;
    total++;
    if (ov != 1 || lg_ovf[r2] !== 1'b1) begin
      bad++; $display("FAIL ovf_pulse: got count=%0d at_rise=%b want 1 1", ov, lg_ovf[r2]);
    end
    extra = 0;
    for (int i = r1 + LAT + 2 * n + HB + 1; i < cyc; i++) if (lg_de[i] !== 1'b0) extra++;
    total++;
    if (extra != 0) begin bad++; $display("FAIL ovf_no_replay: got de_count=%0d want 0", extra); end
    drive_line(p3, 0, r3);
    step(LAT + 2 * (n + HB) + 6);
    o = obs_frame(r3, n); x = exp_frame(p3);
    total++;
    if (o != x) begin bad++; $display("FAIL ovf_third_frame: got %s want %s", o, x); end
  endtask

  task automatic test_saturate();
    pix_q_t p;
    int r, n;
    string o, x;
    p = rand_line(10);
    n = expect_line(p).size();
    drive_line(p, 0, r);
    step(LAT + 2 * (n + HB) + 6);
    o = obs_frame(r, n); x = exp_frame(p);
    total++;
    if (o != x || n != 16) begin
      bad++; $display("FAIL saturate_frame: got %s want %s (slots %0d)", o, x, n);
    end
  endtask

  task automatic test_reset_mid();
    pix_q_t p;
    int r, n, cnt;
    string o, x;
    p = rand_line(6);
    drive_line(p, 0, r);
    step(LAT + 1);
    total++;
    if (de_o !== 1'b1) begin bad++; $display("FAIL rstmid_active: got de=%b want 1", de_o); end
    rst = 1'b1; step(); 
    total++;
    if ({de_o, hs_o} !== 2'b01) begin
      bad++; $display("FAIL rstmid_cut: got de=%b hs=%b want 0 1", de_o, hs_o);
    end
    rst = 1'b0;
    step(80);
    cnt = 0;
    for (int i = r + LAT + 1; i < cyc; i++) if (lg_de[i] !== 1'b0) cnt++;
    total++;
    if (cnt != 0) begin bad++; $display("FAIL rstmid_silent: got de_count=%0d want 0", cnt); end
    p = rand_line(5);
    n = expect_line(p).size();
    drive_line(p, -1, r);
    step(LAT + 2 * (n + HB) + 6);
    o = obs_frame(r, n); x = exp_frame(p);
    total++;
    if (o != x) begin bad++; $display("FAIL rstmid_recover: got %s want %s", o, x); end
  endtask

  task automatic test_bypass();
    pix_q_t p;
    int r, n;
    string o, x;
    logic [PW+2:0] want;
    p = rand_line(5);
    n = expect_line(p).size();
    drive_line(p, 0, r);
    step();
    bypass = 1'b1;
    step(LAT + 2 * (n + HB) + 4);
    o = obs_frame(r, n); x = exp_frame(p);
    total++;
    if (o != x) begin bad++; $display("FAIL bypass_deferred: got %s want %s", o, x); end
    step(3);
    for (int i = 0; i < 24; i++) begin
      di_i = PW'($urandom); de_i = 1'($urandom); hs_i = 1'($urandom); vs_i = 1'($urandom);
      want = {di_i, de_i, hs_i, vs_i};
      step();
      total++;
      if ({do_o, de_o, hs_o, vs_o} !== want) begin
        bad++; $display("FAIL bypass_pass%0d: got %0h want %0h", i, {do_o, de_o, hs_o, vs_o}, want);
      end
    end
    de_i = 1'b0; hs_i = 1'b1; vs_i = 1'b1; bypass = 1'b0;
    step(4);
    p = rand_line(3);
    n = expect_line(p).size();
    drive_line(p, -1, r);
    step(LAT + 2 * (n + HB) + 6);
    o = obs_frame(r, n); x = exp_frame(p);
    total++;
    if (o != x) begin bad++; $display("FAIL bypass_exit_frame: got %s want %s", o, x); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_random();
    test_vs_clear();
    test_overflow();
    test_saturate();
    test_reset_mid();
    test_bypass();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
